if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and issues in-order requests on a req/gnt/rvalid instruction bus.
- Buffers returned instructions in a small FIFO and presents them with a valid/ready handshake to the if_id register, which feeds decode.
- Takes redirects (jump/branch) from execute and drops every in-flight fetch on the wrong path.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding plus buffered fetches (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- jump_flag_i  in  1  redirect request from ex.
- jump_addr_i  in  32  redirect target.
- hold_i  in  1  stall; suppresses new fetch requests.
- ibus_req_o  out  1  fetch request.
- ibus_addr_o  out  32  fetch address (word aligned).
- ibus_gnt_i  in  1  request accepted this cycle.
- ibus_rvalid_i  in  1  response valid (in order, ≥1 cycle after gnt).
- ibus_rdata_i  in  32  instruction word.
- inst_valid_o  out  1  instruction available to if_id.
- inst_addr_o  out  32  PC of presented instruction.
- inst_o  out  32  presented instruction; INST_NOP when not valid.
- inst_ready_i  in  1  if_id accepts this cycle.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - Outputs: ibus_req_o=0, ibus_addr_o=RESET_PC, inst_valid_o=0, inst_addr_o=0, inst_o=INST_NOP (32'h0000_0013).
- Credit rule: ibus_req_o=1 when !hold_i && (fifo_count + outstanding) < FIFO_DEPTH, or when a request is already pending.
- First request goes out in the first clk edge after reset release.
- Request stability: once raised, ibus_req_o and ibus_addr_o stay unchanged until ibus_gnt_i. hold_i does not retract a pending request.
- On gnt:
  - outstanding++.
  - pc += 4, mod 2^32; 0xFFFF_FFFC wraps to 0.
  - The next request may issue the following cycle, which gives back-to-back fetches.
- On rvalid:
  - outstanding--.
  - If discard>0: discard--, data dropped.
  - Otherwise push {addr, data} into the FIFO; the address comes from a parallel in-order tag queue or an addr FIFO.
- Overflow is impossible by the credit rule. Verify with an assertion.
- Output side:
  - inst_valid_o = !fifo_empty; inst_addr_o and inst_o come from the FIFO head.
  - Pop when inst_valid_o && inst_ready_i.
  - Push and pop in the same cycle are both legal, including when the FIFO is full (pop frees the slot combinationally? No: full stays full; credit accounts for it).
  - Latency: gnt at T, rvalid at T+1 → inst_valid_o at T+2.
- Redirect (jump_flag_i=1, single-cycle pulse, sampled at posedge):
  - pc = {jump_addr_i[31:2], 2'b00}.
  - FIFO flushed; inst_valid_o=0 next cycle.
  - discard = outstanding (after this cycle's gnt/rvalid updates).
- Simultaneous events with a redirect:
  - gnt: that request also counts toward discard.
  - rvalid: that response is dropped. If discard was nonzero it consumes the old count; the new discard is computed from the post-update outstanding.
  - Ungranted pending request: it stays on the bus until gnt (stability rule), then is discarded. The next request uses the jump target.
  - hold_i: the redirect still applies.
- A redirect while discard>0 recomputes discard = outstanding; no responses leak.
- pop is ignored on redirect cycles.

Decomposition:
- defines.v:
  - INST_ADDR_BUS, INST_BUS.
  - INST_NOP.
  - RESET_PC default.
  - WRITE_ENABLE/DISABLE style flags reused.
- Sub-module if_fifo: parameterised sync FIFO, width 64 ({addr,inst}).
  - Ports: push/pop/flush/full/empty/count.
  - Same clk/rst conventions.
- Counters outstanding and discard are each $clog2(FIFO_DEPTH)+1 bits and stay in if_fetch.

Test Plan:
- Reset then zero-wait bus (gnt=1, rvalid next cycle), ready=1 → addresses 0x0,0x4,0x8 fetched back-to-back. First inst_valid_o 3 cycles after reset release; inst_addr_o tracks these.
- inst_ready_i=0 held → exactly FIFO_DEPTH (2) requests granted then ibus_req_o=0. Raise ready → one new request per pop; no data lost.
- gnt delayed 3 cycles → ibus_addr_o stays 0x8 throughout; hold_i=1 meanwhile does not drop req.
- jump_flag_i, jump_addr_i=0x100 with 2 fetches outstanding → both responses dropped; next inst_valid_o shows inst_addr_o=0x100.
- jump_addr_i=0x103 in the same cycle as rvalid and gnt → response dropped; granted fetch discarded; next fetch at 0x100.
- Reset asserted mid-burst with 1 outstanding → outputs return to reset values immediately. The stale rvalid after release is tolerated only under the bus-reset contract; otherwise the bench quiesces the bus.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared definitions for the instruction-fetch slice.
//   INST_ADDR_BUS / INST_BUS : address and instruction widths
//   INST_NOP                 : instruction presented when nothing is valid
//   RESET_PC_DEFAULT         : default reset program counter
//   WRITE_ENABLE / _DISABLE  : write-strobe flags
//   fetch_entry_t            : {addr, inst} word stored in the fetch buffer
package if_fetch_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic [INST_BUS-1:0]      INST_NOP         = 32'h0000_0013;
  localparam logic [INST_ADDR_BUS-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef struct packed {
    logic [INST_ADDR_BUS-1:0] addr;
    logic [INST_BUS-1:0]      inst;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_BUS-1:0] align_word(input logic [INST_ADDR_BUS-1:0] a);
    return {a[INST_ADDR_BUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// if_fifo: parameterised synchronous FIFO with flush.
//   clk, rst (async, active-low)
//   push, push_data : write one entry (ignored when full unless popping)
//   pop             : remove the head entry (ignored when empty)
//   flush           : empty the FIFO; takes priority over push/pop
//   head            : current head entry (undefined when empty)
//   full, empty, count : occupancy status
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The owner's credit scheme must never push into a full FIFO without a pop.
  assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage.
//   clk, rst (async, active-low)
//   jump_flag_i, jump_addr_i : redirect from execute
//   hold_i                   : stall, blocks new fetch requests
//   ibus_req_o, ibus_addr_o, ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i : instruction bus
//   inst_valid_o, inst_addr_o, inst_o, inst_ready_i : valid/ready output to if_id
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                       FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jump_flag_i,
  input  logic [INST_ADDR_BUS-1:0] jump_addr_i,
  input  logic                     hold_i,
  output logic                     ibus_req_o,
  output logic [INST_ADDR_BUS-1:0] ibus_addr_o,
  input  logic                     ibus_gnt_i,
  input  logic                     ibus_rvalid_i,
  input  logic [INST_BUS-1:0]      ibus_rdata_i,
  output logic                     inst_valid_o,
  output logic [INST_ADDR_BUS-1:0] inst_addr_o,
  output logic [INST_BUS-1:0]      inst_o,
  input  logic                     inst_ready_i
);

  localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   ONE        = CW'(1);
  localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  logic [INST_ADDR_BUS-1:0] pc_q;
  logic [INST_ADDR_BUS-1:0] req_addr_q;
  logic [INST_ADDR_BUS-1:0] pc_src;
  logic                     req_q;
  logic                     stale_q;
  logic [CW-1:0]            outstanding_q;
  logic [CW-1:0]            discard_q;
  logic [CW-1:0]            out_next;
  logic [CW-1:0]            discard_next;
  logic [CW-1:0]            count_next;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            tag_count_unused;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     tag_full;
  logic                     tag_empty;
  logic                     gnt_fire;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     bus_free;
  logic                     credit_ok;
  logic                     issue;
  logic [INST_ADDR_BUS-1:0] tag_head;
  fetch_entry_t             head;
  logic                     unused_ok;

  assign unused_ok = &{1'b0, tag_count_unused, tag_full, fifo_full, jump_addr_i[1:0]};

  assign ibus_req_o  = req_q;
  assign ibus_addr_o = req_addr_q;

  assign gnt_fire  = req_q && ibus_gnt_i;
  // Responses are dropped while wrong-path fetches drain and on the redirect cycle itself.
  assign fifo_push = (ibus_rvalid_i && !tag_empty && (discard_q == '0) && !jump_flag_i)
                     ? WRITE_ENABLE : WRITE_DISABLE;
  assign fifo_pop  = !fifo_empty && inst_ready_i && !jump_flag_i;

  // The bus is free for a new request once nothing is pending or the pending one is granted.
  assign bus_free = !req_q || ibus_gnt_i;
  assign pc_src   = jump_flag_i ? align_word(jump_addr_i) : pc_q;

  always_comb begin
    out_next = outstanding_q;
    if (gnt_fire)      out_next = out_next + ONE;
    if (ibus_rvalid_i) out_next = out_next - ONE;

    count_next = fifo_count;
    if (jump_flag_i) begin
      count_next = '0;
    end else begin
      if (fifo_push) count_next = count_next + ONE;
      if (fifo_pop)  count_next = count_next - ONE;
    end

    // A redirect marks everything still in flight (including this cycle's grant) as wrong-path.
    // A request that was pending across a redirect is discarded once it is finally granted.
    if (jump_flag_i) begin
      discard_next = out_next;
    end else begin
      discard_next = discard_q;
      if (ibus_rvalid_i && (discard_q != '0)) discard_next = discard_next - ONE;
      if (gnt_fire && stale_q)                discard_next = discard_next + ONE;
    end
  end

  // Credit uses post-update occupancy, so buffered plus in-flight never exceeds FIFO_DEPTH.
  assign credit_ok = ({1'b0, count_next} + {1'b0, out_next}) < CREDIT_MAX;
  assign issue     = bus_free && !hold_i && credit_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      req_q         <= 1'b0;
      req_addr_q    <= RESET_PC;
      stale_q       <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= out_next;
      discard_q     <= discard_next;
      if (issue) begin
        req_q      <= 1'b1;
        req_addr_q <= pc_src;
        pc_q       <= pc_src + 32'd4;
      end else begin
        pc_q <= pc_src;
        if (bus_free) req_q <= 1'b0;
      end
      if (jump_flag_i && req_q && !ibus_gnt_i) stale_q <= 1'b1;
      else if (gnt_fire)                       stale_q <= 1'b0;
    end
  end

  // In-order address tags for granted requests; popped by every response, kept or dropped.
  if_fifo #(.WIDTH(INST_ADDR_BUS), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (gnt_fire),
    .push_data (req_addr_q),
    .pop       (ibus_rvalid_i),
    .flush     (1'b0),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count_unused)
  );

  if_fifo #(.WIDTH(INST_ADDR_BUS + INST_BUS), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({tag_head, ibus_rdata_i}),
    .pop       (fifo_pop),
    .flush     (jump_flag_i),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign inst_valid_o = !fifo_empty;
  assign inst_addr_o  = inst_valid_o ? head.addr : '0;
  assign inst_o       = inst_valid_o ? head.inst : INST_NOP;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scoreboard bench for if_fetch with a directed bus responder.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_i = 1'b0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_o;
  logic        inst_ready_i = 1'b1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] bus_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          gnt_budget = 0;
  int          grant_count = 0;
  logic        rsp_hold = 1'b0;

  if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_i        (hold_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_addr_o   (inst_addr_o),
    .inst_o        (inst_o),
    .inst_ready_i  (inst_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic expectFetch(input logic [31:0] addr);
    exp_t e;
    e.addr = addr;
    e.data = mem_word(addr);
    exp_q.push_back(e);
  endtask

  // Bus responder: responses come back in order, at least one cycle after their grant.
  task automatic busStep();
    if (!rst) begin
      ibus_gnt_i    = 1'b0;
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = '0;
      bus_q.delete();
    end else begin
      if (!rsp_hold && bus_q.size() > 0) begin
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = mem_word(bus_q.pop_front());
      end else begin
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = '0;
      end
      if (ibus_req_o && gnt_budget > 0) begin
        ibus_gnt_i = 1'b1;
        bus_q.push_back(ibus_addr_o);
        gnt_budget--;
        grant_count++;
      end else begin
        ibus_gnt_i = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int cycles = 1);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      busStep();
    end
  endtask

  task automatic holdReset();
    rst          = 1'b0;
    jump_flag_i  = 1'b0;
    jump_addr_i  = '0;
    hold_i       = 1'b0;
    inst_ready_i = 1'b1;
    gnt_budget   = 0;
    grant_count  = 0;
    rsp_hold     = 1'b0;
    exp_q.delete();
    applyStimulus(2);
  endtask

  task automatic checkDrained(input string name, input int grants);
    checkOutput({name, " scoreboard empty"}, 32'(exp_q.size()), 32'd0);
    checkOutput({name, " grant count"}, 32'(grant_count), 32'(grants));
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && inst_valid_o && inst_ready_i && !jump_flag_i) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected instruction: got addr %h inst %h, expected none", inst_addr_o, inst_o);
        end else begin
          e = exp_q.pop_front();
          checkOutput("inst_addr", inst_addr_o, e.addr);
          checkOutput("inst_data", inst_o, e.data);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int i;

    // Reset values
    holdReset();
    checkOutput("reset req", 32'(ibus_req_o), 32'd0);
    checkOutput("reset addr", ibus_addr_o, 32'h0);
    checkOutput("reset valid", 32'(inst_valid_o), 32'd0);
    checkOutput("reset inst_addr", inst_addr_o, 32'h0);
    checkOutput("reset inst", inst_o, INST_NOP);

    // Zero-wait bus: 0,4,8 fetched, first valid three edges after release
    gnt_budget = 3;
    expectFetch(32'h0); expectFetch(32'h4); expectFetch(32'h8);
    rst = 1'b1;
    applyStimulus();
    checkOutput("t1 first req", 32'(ibus_req_o), 32'd1);
    checkOutput("t1 first addr", ibus_addr_o, 32'h0);
    checkOutput("t1 valid e1", 32'(inst_valid_o), 32'd0);
    applyStimulus();
    checkOutput("t1 second addr", ibus_addr_o, 32'h4);
    checkOutput("t1 valid e2", 32'(inst_valid_o), 32'd0);
    applyStimulus();
    checkOutput("t1 valid e3", 32'(inst_valid_o), 32'd1);
    checkOutput("t1 inst_addr e3", inst_addr_o, 32'h0);
    applyStimulus(8);
    checkDrained("t1", 3);

    // Backpressure: only FIFO_DEPTH grants, then one request per pop
    holdReset();
    inst_ready_i = 1'b0;
    gnt_budget = 4;
    expectFetch(32'h0); expectFetch(32'h4); expectFetch(32'h8); expectFetch(32'hC);
    rst = 1'b1;
    applyStimulus(6);
    checkOutput("t2 grants held", 32'(grant_count), 32'd2);
    checkOutput("t2 req low", 32'(ibus_req_o), 32'd0);
    checkOutput("t2 head addr", inst_addr_o, 32'h0);
    inst_ready_i = 1'b1;
    applyStimulus(10);
    checkDrained("t2", 4);

    // Delayed grant under hold: request and address stay stable
    holdReset();
    gnt_budget = 2;
    expectFetch(32'h0); expectFetch(32'h4); expectFetch(32'h8);
    rst = 1'b1;
    i = 0;
    while (i < 12 && !(ibus_req_o && ibus_addr_o == 32'h8)) begin
      applyStimulus();
      i++;
    end
    checkOutput("t3 reached addr 8", 32'(ibus_req_o && ibus_addr_o == 32'h8), 32'd1);
    hold_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("t3 req held", 32'(ibus_req_o), 32'd1);
      checkOutput("t3 addr held", ibus_addr_o, 32'h8);
    end
    gnt_budget = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("t3 req after hold grant", 32'(ibus_req_o), 32'd0);
    hold_i = 1'b0;
    applyStimulus(6);
    checkDrained("t3", 3);

    // Redirect with two fetches outstanding: both responses dropped
    holdReset();
    gnt_budget = 3;
    rsp_hold = 1'b1;
    expectFetch(32'h100);
    rst = 1'b1;
    applyStimulus(3);
    checkOutput("t4 credit exhausted", 32'(ibus_req_o), 32'd0);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    applyStimulus();
    jump_flag_i = 1'b0;
    rsp_hold = 1'b0;
    checkOutput("t4 valid after jump", 32'(inst_valid_o), 32'd0);
    i = 0;
    while (i < 10 && !ibus_req_o) begin
      applyStimulus();
      i++;
    end
    checkOutput("t4 target req", 32'(ibus_req_o), 32'd1);
    checkOutput("t4 target addr", ibus_addr_o, 32'h100);
    applyStimulus(6);
    checkDrained("t4", 3);

    // Redirect to unaligned target alongside rvalid and gnt
    holdReset();
    gnt_budget = 3;
    expectFetch(32'h100);
    rst = 1'b1;
    applyStimulus(2);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h103;
    applyStimulus();
    jump_flag_i = 1'b0;
    checkOutput("t5 aligned target addr", ibus_addr_o, 32'h100);
    checkOutput("t5 target req", 32'(ibus_req_o), 32'd1);
    applyStimulus(6);
    checkDrained("t5", 3);

    // Redirect over a pending request, then PC wrap at the top of memory
    holdReset();
    gnt_budget = 0;
    expectFetch(32'hFFFF_FFFC); expectFetch(32'h0);
    rst = 1'b1;
    applyStimulus();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    applyStimulus();
    jump_flag_i = 1'b0;
    checkOutput("t6 pending req kept", 32'(ibus_req_o), 32'd1);
    checkOutput("t6 pending addr kept", ibus_addr_o, 32'h0);
    gnt_budget = 3;
    applyStimulus(8);
    checkDrained("t6", 3);

    // Redirect flushes a full FIFO
    holdReset();
    inst_ready_i = 1'b0;
    gnt_budget = 2;
    expectFetch(32'h40);
    rst = 1'b1;
    applyStimulus(6);
    checkOutput("t7 fifo valid before flush", 32'(inst_valid_o), 32'd1);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h40;
    gnt_budget = 1;
    applyStimulus();
    jump_flag_i = 1'b0;
    checkOutput("t7 valid after flush", 32'(inst_valid_o), 32'd0);
    checkOutput("t7 target addr", ibus_addr_o, 32'h40);
    inst_ready_i = 1'b1;
    applyStimulus(6);
    checkDrained("t7", 3);

    // Reset mid-burst with one fetch outstanding
    holdReset();
    inst_ready_i = 1'b0;
    gnt_budget = 10;
    rst = 1'b1;
    applyStimulus(3);
    checkOutput("t8 valid before reset", 32'(inst_valid_o), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("t8 req in reset", 32'(ibus_req_o), 32'd0);
    checkOutput("t8 addr in reset", ibus_addr_o, 32'h0);
    checkOutput("t8 valid in reset", 32'(inst_valid_o), 32'd0);
    checkOutput("t8 inst_addr in reset", inst_addr_o, 32'h0);
    checkOutput("t8 inst in reset", inst_o, INST_NOP);
    holdReset();
    gnt_budget = 1;
    expectFetch(32'h0);
    rst = 1'b1;
    applyStimulus(6);
    checkDrained("t8", 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
